rr_arb2_stream: RTL and testbench

//   Two-input round-robin stream arbiter that generates the select for a 2:1 mux
//   and registers the muxed beat. It sits upstream of the shared 2:1 datapath
//   mux and merges two valid/ready sources into one output stream. A packet

---
 rtl/rr_arb2_stream.sv | 168 ++++++++++++++++
 tb/tb_rr_arb2_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb2_stream.sv
// -----------------------------------------------------------------------------
// rr_arb2_stream
//
// Two-input round-robin stream arbiter with a registered 2:1 output stage.
// Two valid/ready sources are merged into one registered output stream. The
// registered select (out_src) tells the shared downstream datapath which side
// the current beat came from. With LOCK_ON_LAST=1 the grant is held on one
// source from its first beat until the beat carrying `last` has been taken,
// so packets are never interleaved.
//
// Parameters
//   WIDTH         data width of each input and of the output
//   LOCK_ON_LAST  1: hold grant for a whole packet; 0: re-arbitrate every beat
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in0_valid/ready     source 0 handshake (ready = beat accepted this cycle
//                       when valid is also high)
//   in0_data/last       source 0 payload and end-of-packet marker
//   in1_valid/ready     source 1 handshake
//   in1_data/last       source 1 payload and end-of-packet marker
//   out_valid/ready     registered output handshake
//   out_data/last       registered muxed payload
//   out_src             registered mux select of the beat on the output
//   busy                high while a packet holds the grant
// -----------------------------------------------------------------------------
module rr_arb2_stream #(
  parameter int WIDTH        = 8,
  parameter bit LOCK_ON_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;

  logic             load;
  logic [1:0]       valid_vec;
  logic [1:0]       slot_open;
  logic [1:0]       take;
  logic             sel_src;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             end_pkt;

  // The output register can accept a new beat when it is empty or being
  // drained on this very edge.
  assign load      = ~out_valid_q | out_ready;
  assign valid_vec = {in1_valid, in0_valid};

  // slot_open[i] says source i would win this cycle if it presents a beat.
  // It is built only from the state, the priority and the *other* source's
  // valid, so no ready ever depends on its own valid. Both slots may be open
  // when at most one source can actually use them, which keeps the resulting
  // transfer one-hot.
  always_comb begin
    slot_open = 2'b00;
    case (state_q)
      ST_ARB: begin
        slot_open[0] = ~in1_valid | ~prio_q;
        slot_open[1] = ~in0_valid |  prio_q;
      end
      ST_HOLD0: slot_open[0] = 1'b1;
      ST_HOLD1: slot_open[1] = 1'b1;
      default:  slot_open = 2'b00;
    endcase
  end

  assign in0_ready = load & slot_open[0];
  assign in1_ready = load & slot_open[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_take
      assign take[gi] = valid_vec[gi] & load & slot_open[gi];
    end
  endgenerate

  // 2:1 mux of the winning beat; take is one-hot or zero.
  assign sel_src  = take[1];
  assign sel_data = take[1] ? in1_data : in0_data;
  assign sel_last = take[1] ? in1_last : in0_last;

  // Without packet locking every beat closes its own "packet".
  assign end_pkt  = LOCK_ON_LAST ? sel_last : 1'b1;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (load) begin
      if (|take) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_last_d  = sel_last;
        out_src_d   = sel_src;
        if (end_pkt) begin
          state_d = ST_ARB;
          prio_d  = ~sel_src;
        end else begin
          state_d = sel_src ? ST_HOLD1 : ST_HOLD0;
          // Inside a held packet priority is frozen; it only moves on the
          // opening beat (from ARB) and again on the closing beat.
          if (state_q == ST_ARB) begin
            prio_d = ~sel_src;
          end
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q != ST_ARB);

endmodule

// File: tb/tb_rr_arb2_stream.sv
// -----------------------------------------------------------------------------
// tb_rr_arb2_stream
//
// Two arbiter instances run side by side: g_inst[0] with packet locking and
// g_inst[1] without. Each instance has its own pair of randomized sources, a
// behavioural arbitration model, an expected-beat queue filled when a beat is
// granted, and a monitor that pops and compares whenever the output beat is
// accepted. Phases (directed patterns, then random traffic) are selected by
// shared phase settings written from the main initial block.
// -----------------------------------------------------------------------------
module tb_rr_arb2_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Phase settings shared by both instances.
  int k_phase = 0;
  int k_pv[2];
  int k_lmin[2];
  int k_lmax[2];
  int k_base[2];
  int k_step[2];
  int k_prdy = 100;
  bit k_seq = 1'b0;
  bit k_endchk = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam bit LOCK = (gi == 0);

      logic       in0_valid = 1'b0, in1_valid = 1'b0;
      logic       in0_last = 1'b0, in1_last = 1'b0;
      logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
      logic       out_ready = 1'b0;
      logic       in0_ready, in1_ready;
      logic       out_valid, out_last, out_src, busy;
      logic [7:0] out_data;

      rr_arb2_stream #(.WIDTH(8), .LOCK_ON_LAST(LOCK)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in0_data(in0_data), .in0_last(in0_last),
        .in1_valid(in1_valid), .in1_ready(in1_ready),
        .in1_data(in1_data), .in1_last(in1_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .busy(busy)
      );

      // Reference model: who is owed the next grant, which source (if any)
      // owns an open packet, and whether the output stage holds a beat.
      int         prio = 0;
      int         owner = -1;
      int         win = -1;
      bit         mov = 1'b0;
      bit         mload = 1'b0;
      bit         jr = 1'b0;
      logic [9:0] exp_q[$];

      // Source state: a beat is held until it is transferred.
      bit         hb[2];
      logic [7:0] cd[2];
      bit         cl[2];
      int         plen[2];
      int         cnt[2];
      bit         v[2];
      int         last_phase = -1;
      bit         prev_stall = 1'b0;
      logic [9:0] saved = '0;
      bit         end_done = 1'b0;

      // Driver + model, one step per cycle just after the rising edge.
      initial begin
        for (int s = 0; s < 2; s++) begin
          hb[s] = 1'b0; cd[s] = 8'h00; cl[s] = 1'b0; plen[s] = 0; cnt[s] = 0; v[s] = 1'b0;
        end
        forever begin
          @(posedge clk);
          #1;
          // Apply the decision that was due on this edge.
          if (rst) begin
            mov = 1'b0; owner = -1; prio = 0; jr = 1'b1;
            exp_q.delete();
          end else if (mload && win >= 0) begin
            mov   = 1'b1;
            prio  = 1 - win;
            owner = (LOCK && !cl[win]) ? win : -1;
            hb[win] = 1'b0;
          end else if (mload) begin
            mov = 1'b0;
          end

          if (k_phase != last_phase) begin
            last_phase = k_phase;
            for (int s = 0; s < 2; s++) begin
              cnt[s] = 0; hb[s] = 1'b0; plen[s] = 0;
            end
          end

          for (int s = 0; s < 2; s++) begin
            if (!hb[s]) begin
              hb[s] = 1'b1;
              cd[s] = k_seq ? 8'(k_base[s] + k_step[s] * cnt[s]) : 8'($urandom);
              cnt[s]++;
              if (plen[s] == 0) plen[s] = int'($urandom_range(k_lmax[s], k_lmin[s]));
              cl[s] = (plen[s] == 1);
              plen[s]--;
            end
            v[s] = hb[s] && (int'($urandom_range(99, 0)) < k_pv[s]);
          end

          in0_valid = v[0]; in0_data = cd[0]; in0_last = cl[0];
          in1_valid = v[1]; in1_data = cd[1]; in1_last = cl[1];
          out_ready = (int'($urandom_range(99, 0)) < k_prdy);

          // Decide the winner for the coming edge.
          mload = !mov || out_ready;
          win = -1;
          if (owner >= 0) begin
            if (v[owner]) win = owner;
          end else if (v[0] && v[1]) win = prio;
          else if (v[0]) win = 0;
          else if (v[1]) win = 1;
          if (mload && win >= 0) exp_q.push_back({1'(win), cl[win], cd[win]});
        end
      end

      // Monitor, mid-cycle on the falling edge.
      initial begin
        logic [9:0] e;
        logic [9:0] got;
        forever begin
          @(negedge clk);
          got = {out_src, out_last, out_data};
          if (rst) begin
            prev_stall = 1'b0;
          end else begin
            if (jr) begin
              checks++;
              if (got !== 10'h000) begin
                errors++;
                $display("FAIL reset_regs inst%0d: got src/last/data %h, want 000", gi, got);
              end
              jr = 1'b0;
            end
            checks++;
            if (out_valid !== mov) begin
              errors++;
              $display("FAIL out_valid inst%0d t=%0t: got %b, want %b", gi, $time, out_valid, mov);
            end
            checks++;
            if (busy !== (owner >= 0)) begin
              errors++;
              $display("FAIL busy inst%0d t=%0t: got %b, want %b", gi, $time, busy, owner >= 0);
            end
            if (in0_valid) begin
              checks++;
              if (in0_ready !== (mload && win == 0)) begin
                errors++;
                $display("FAIL in0_ready inst%0d t=%0t: got %b, want %b", gi, $time, in0_ready, mload && win == 0);
              end
            end
            if (in1_valid) begin
              checks++;
              if (in1_ready !== (mload && win == 1)) begin
                errors++;
                $display("FAIL in1_ready inst%0d t=%0t: got %b, want %b", gi, $time, in1_ready, mload && win == 1);
              end
            end
            if (prev_stall) begin
              checks++;
              if (got !== saved || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold inst%0d t=%0t: got %h v=%b, want %h v=1", gi, $time, got, out_valid, saved);
              end
            end
            if (out_valid && out_ready) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat inst%0d t=%0t: got %h, want no beat", gi, $time, got);
              end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                  errors++;
                  $display("FAIL beat inst%0d t=%0t: got src/last/data %h, want %h", gi, $time, got, e);
                end else begin
                  $display("inst%0d t=%0t beat src=%0d last=%0d data=%h", gi, $time, out_src, out_last, out_data);
                end
              end
            end
            prev_stall = out_valid && !out_ready;
            saved = got;
            if (k_endchk && !end_done) begin
              checks++;
              if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain inst%0d: got %0d beats pending, want 0", gi, exp_q.size());
              end
              end_done = 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // All phase-control changes happen 2 time units after a rising edge.
  task automatic phase(input int cycles, input int pv0, input int pv1, input int prdy,
                       input int lmin0, input int lmax0, input int lmin1, input int lmax1,
                       input bit seq, input int b0, input int s0, input int b1, input int s1);
    k_pv[0] = pv0; k_pv[1] = pv1; k_prdy = prdy;
    k_lmin[0] = lmin0; k_lmax[0] = lmax0; k_lmin[1] = lmin1; k_lmax[1] = lmax1;
    k_seq = seq; k_base[0] = b0; k_step[0] = s0; k_base[1] = b1; k_step[1] = s1;
    k_phase++;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      k_pv[s] = 0; k_lmin[s] = 1; k_lmax[s] = 1; k_base[s] = 0; k_step[s] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // in0 only, single-beat packets 0x11, 0x22, ...
    phase(4, 100, 0, 100, 1, 1, 1, 1, 1'b1, 'h11, 'h11, 0, 0);
    // both always valid, single-beat packets: strict alternation
    phase(12, 100, 100, 100, 1, 1, 1, 1, 1'b1, 'hA0, 1, 'hB0, 1);
    // in0 3-beat packets against in1 single beats (lock vs per-beat)
    phase(15, 100, 100, 100, 3, 3, 1, 1, 1'b1, 'h30, 1, 'hC0, 1);
    // backpressure for 4 cycles, then release
    phase(6, 100, 100, 100, 1, 2, 1, 2, 1'b0, 0, 0, 0, 0);
    phase(4, 100, 100, 0, 1, 2, 1, 2, 1'b0, 0, 0, 0, 0);
    phase(6, 100, 100, 100, 1, 2, 1, 2, 1'b0, 0, 0, 0, 0);
    // reset in the middle of an in1 packet, then both valid
    phase(4, 0, 100, 100, 1, 1, 6, 6, 1'b1, 'h70, 1, 'hE0, 1);
    do_reset();
    phase(8, 100, 100, 100, 1, 1, 1, 1, 1'b1, 'h80, 1, 'h90, 1);
    // random traffic with random packet lengths and valid drops
    for (int i = 0; i < 6; i++) begin
      phase(200, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
            int'($urandom_range(100, 20)), 1, int'($urandom_range(5, 1)),
            1, int'($urandom_range(5, 1)), 1'b0, 0, 0, 0, 0);
    end
    // drain
    phase(10, 0, 0, 100, 1, 1, 1, 1, 1'b0, 0, 0, 0, 0);
    k_endchk = 1'b1;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
